// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
// Holds the sequencer state codes, the frame layout, the frame length and
// the microsecond-to-cycle conversion used to size the host timers.
package ps2_pkg;

  // Full host-to-device frame: start, 8 data, parity, stop.
  localparam int PS2_BITS = 11;

  // Sequencer state codes (kept as plain constants for older tool flows).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_ERR       = 3'd7;

  // Bits the host still has to present after the start bit, LSB first.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 1000000) * us;
  endfunction

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic ps2_frame_t make_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a client and the PS/2 host
// transmitter. The client (master) offers a byte with tx_valid/tx_data and
// observes tx_ready plus the tx_done / tx_err completion pulses.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: two-flop synchronizer for one raw PS/2 line plus a
// falling-edge detector on the synchronized value. Everything resets to
// the idle-high level so a reset never produces a spurious edge.
module ps2_sync_edge (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain followed by one cycle of history for edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Inhibits the bus, issues request-to-send, shifts data/parity/stop on the
// device's falling clock edges, samples the device ack and reports
// tx_done or tx_err. A single down-counter times both the inhibit phase
// and the overall transfer timeout.
// Build option: define PS2_TX_ACK_CHECK_EN to turn a device NACK into
// tx_err; otherwise the ack bit is awaited but its value ignored.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | ready for a command, both lines released
// INHIBIT    | host holds clock low for the inhibit time
// RTS        | clock released, data held low (start bit), timeout armed
// SHIFT      | present data[0..7], parity, stop on device falling edges
// ACK        | wait for the ack clock edge and sample the data line
// WAIT_IDLE  | wait for the device to release both lines
// DONE       | one-cycle tx_done, then IDLE
// ERR        | one-cycle tx_err (timeout or NACK), lines released
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned INHIBIT_US  = 100,
  parameter int unsigned TIMEOUT_US  = 15000
) (
  input  logic           clock,
  input  logic           resetn,
  ps2_host_tx_if.slave   tx,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int unsigned INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int unsigned TO_CYC  = us_to_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int unsigned TMR_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
  localparam int          TMR_W   = $clog2(TMR_MAX + 1);

  // Inhibit: loaded on accept, counts INH_CYC cycles down to zero.
  localparam logic [TMR_W-1:0] INH_LOAD = TMR_W'(INH_CYC - 1);
  // Timeout: loaded in RTS so that ERR lands exactly TO_CYC cycles after
  // the RTS cycle (one cycle for the load, one for the ERR transition).
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(TO_CYC - 2);

  // Falling edge that makes the host present the stop bit.
  localparam logic [3:0] LAST_BIT = 4'(PS2_BITS - 2);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [TMR_W-1:0]      timer;
  logic [PS2_BITS-2:0]   frame_q;
  logic [3:0]            bit_cnt;
  logic                  data_drv;

  logic                  clk_sync;
  logic                  clk_fall;
  logic                  data_sync;
  logic                  data_fall_unused;

  logic                  accept;
  logic                  tmr_zero;
  logic                  in_xfer;
  logic                  timed_out;
  logic                  shift_en;
  logic                  nack_fatal;

  ps2_sync_edge u_sync_clk (
    .clock  (clock),
    .resetn (resetn),
    .din    (ps2_clk_in),
    .sync   (clk_sync),
    .fall   (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clock  (clock),
    .resetn (resetn),
    .din    (ps2_data_in),
    .sync   (data_sync),
    .fall   (data_fall_unused)
  );

  assign accept    = (state == ST_IDLE) && tx.tx_valid;
  assign tmr_zero  = (timer == '0);
  assign in_xfer   = state inside {ST_SHIFT, ST_ACK, ST_WAIT_IDLE};
  assign timed_out = in_xfer && tmr_zero;
  assign shift_en  = (state == ST_SHIFT) && !timed_out && clk_fall;

`ifdef PS2_TX_ACK_CHECK_EN
  // A released (high) data line at the ack edge means the device NACKed.
  assign nack_fatal = data_sync;
`else
  assign nack_fatal = 1'b0;
`endif

  // Next-state decode; timeout has priority over any line activity.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (tx.tx_valid) state_nxt = ST_INHIBIT;
      ST_INHIBIT:   if (tmr_zero) state_nxt = ST_RTS;
      ST_RTS:       state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (timed_out)                            state_nxt = ST_ERR;
        else if (clk_fall && bit_cnt == LAST_BIT) state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (timed_out)     state_nxt = ST_ERR;
        else if (clk_fall) state_nxt = nack_fatal ? ST_ERR : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timed_out)                  state_nxt = ST_ERR;
        else if (clk_sync && data_sync) state_nxt = ST_DONE;
      end
      ST_DONE:      state_nxt = ST_IDLE;
      ST_ERR:       state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Shared down-counter: inhibit length first, then the transfer timeout.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      timer <= '0;
    end else if (accept) begin
      timer <= INH_LOAD;
    end else if (state == ST_RTS) begin
      timer <= TO_LOAD;
    end else if (!tmr_zero && (state == ST_INHIBIT || in_xfer)) begin
      timer <= timer - TMR_W'(1);
    end
  end

  // Frame shifter and data-line drive; a bit appears the cycle after the
  // falling edge that requested it, and the stop bit (1) releases the line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      frame_q  <= '1;
      bit_cnt  <= '0;
      data_drv <= 1'b0;
    end else begin
      if (accept) begin
        frame_q <= make_frame(tx.tx_data);
        bit_cnt <= '0;
      end
      if (state == ST_INHIBIT && tmr_zero) begin
        data_drv <= 1'b1;
      end else if (shift_en) begin
        data_drv <= ~frame_q[0];
        frame_q  <= {1'b1, frame_q[PS2_BITS-2:1]};
        bit_cnt  <= bit_cnt + 4'd1;
      end else if (state_nxt == ST_ERR || state_nxt == ST_IDLE) begin
        data_drv <= 1'b0;
      end
    end
  end

  assign ps2_clk_oe  = (state == ST_INHIBIT);
  assign ps2_data_oe = data_drv;

  assign tx.tx_ready = (state == ST_IDLE);
  assign tx.tx_done  = (state == ST_DONE);
  assign tx.tx_err   = (state == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain bus
// model and a behavioural PS/2 device clocking at 12.5 kHz. The DUT runs
// with a 2 MHz clock parameter so timer lengths stay short.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ  = 2000000;
  localparam int unsigned INH_US  = 100;
  localparam int unsigned TO_US   = 5000;
  localparam int          INH_EXP = 200;    // 2 cycles/us * 100 us
  localparam int          TO_EXP  = 10000;  // 2 cycles/us * 5000 us
  localparam int          HALF    = 80;     // half of a 12.5 kHz period

`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic NACK_DONE = 1'b0;
`else
  localparam logic NACK_DONE = 1'b1;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       nack;
    logic       par;
    logic       exp_done;
  } vec_t;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b0;   // 1 = device pulls clock low
  logic dev_data = 1'b0;  // 1 = device pulls data low

  int total = 0;
  int bad = 0;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .INHIBIT_US  (INH_US),
    .TIMEOUT_US  (TO_US)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .tx          (tx_if),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clock = ~clock;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
  assign ps2_data_in = ~(ps2_data_oe | dev_data);

  // Bus observer
  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;
  int   inh_run = 0, last_inh = 0, rts_cyc = 0, err_cyc = 0, acc_at_done = 0;
  logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0, prev_done = 1'b0;
  logic rdy_at_done = 1'b0, rdy_after_done = 1'b0, err_oe = 1'b0;

  always @(posedge clock) begin
    if (tx_if.tx_valid && tx_if.tx_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    prev_clk_oe <= ps2_clk_oe;
    prev_data_oe <= ps2_data_oe;
    prev_done <= tx_if.tx_done;
    if (ps2_clk_oe) inh_run <= prev_clk_oe ? inh_run + 1 : 1;
    else if (prev_clk_oe) last_inh <= inh_run;
    if (ps2_data_oe && !prev_data_oe) rts_cyc <= cyc;
    if (tx_if.tx_done) begin
      done_cnt <= done_cnt + 1;
      rdy_at_done <= tx_if.tx_ready;
      acc_at_done <= acc_cnt;
    end
    if (prev_done) rdy_after_done <= tx_if.tx_ready;
    if (tx_if.tx_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
      err_oe <= ps2_clk_oe | ps2_data_oe;
    end
    if (tx_if.tx_done && tx_if.tx_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    tx_if.tx_data = d;
    tx_if.tx_valid = 1'b1;
    while (tx_if.tx_ready !== 1'b1 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    check("accept_wait_expired", (n >= 20000), 0);
    @(negedge clock);
    tx_if.tx_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, then clock npulse times; bit i is
  // sampled just before the rising edge of pulse i. Pulse 10 carries the ack.
  task automatic dev_receive(input int npulse, input logic nack,
                             output logic [9:0] bits, output logic ok);
    int n = 0;
    bits = '0;
    ok = 1'b1;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) begin
      ok = 1'b0;
      return;
    end
    repeat (40) @(negedge clock);
    for (int i = 0; i < npulse; i++) begin
      if (i == 10) begin
        dev_data = ~nack;
        repeat (4) @(negedge clock);
      end
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clock);
      if (i < 10) bits[i] = ps2_data_in;
      dev_clk = 1'b0;
      dev_data = 1'b0;
      repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("outcome_wait_expired", (n >= 2000), 0);
    repeat (6) @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v);
    logic [9:0] bits;
    logic ok;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(v.data);
    dev_receive(11, v.nack, bits, ok);
    check("dev_saw_rts", ok, 1);
    check("data_bits", bits[7:0], v.data);
    check("parity_bit", bits[8], v.par);
    check("stop_bit", bits[9], 1);
    wait_outcome(d0, e0);
    check("done_pulses", done_cnt - d0, v.exp_done);
    check("err_pulses", err_cnt - e0, !v.exp_done);
    check("inhibit_len", last_inh, INH_EXP);
    check("oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
    if (v.exp_done) begin
      check("ready_in_done", rdy_at_done, 0);
      check("ready_after_done", rdy_after_done, 1);
    end else begin
      check("oe_in_err", err_oe, 0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vec_t v01;
    logic [9:0] bits;
    logic ok;
    int d0, e0, a0, n;

    vecs[0] = '{data: 8'hED, nack: 1'b0, par: 1'b1, exp_done: 1'b1};
    vecs[1] = '{data: 8'hF4, nack: 1'b0, par: 1'b0, exp_done: 1'b1};
    vecs[2] = '{data: 8'h00, nack: 1'b1, par: 1'b1, exp_done: NACK_DONE};
    vecs[3] = '{data: 8'h80, nack: 1'b0, par: 1'b0, exp_done: 1'b1};
    v01     = '{data: 8'h01, nack: 1'b0, par: 1'b0, exp_done: 1'b1};

    tx_if.tx_data = 8'h00;
    tx_if.tx_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_pulses", {tx_if.tx_done, tx_if.tx_err}, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Device never clocks: timeout measured from the RTS cycle.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF);
    n = 0;
    while (err_cnt == e0 && n < 15000) begin
      @(negedge clock);
      n++;
    end
    check("timeout_wait_expired", (n >= 15000), 0);
    repeat (4) @(negedge clock);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_cycles", err_cyc - rts_cyc, TO_EXP);
    check("timeout_oe_in_err", err_oe, 0);
    check("timeout_oe_after", {ps2_clk_oe, ps2_data_oe}, 0);

    // Reset mid-transfer after the 4th data bit is on the line.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00);
    dev_receive(4, 1'b0, bits, ok);
    check("abort_dev_saw_rts", ok, 1);
    check("abort_pre_data_oe", ps2_data_oe, 1);
    #3 resetn = 1'b0;
    #1;
    check("abort_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("abort_ready", tx_if.tx_ready, 1);
    check("abort_pulses", {tx_if.tx_done, tx_if.tx_err}, 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_err", err_cnt - e0, 0);
    run_vec(v01);

    // 0xAA held on tx_valid throughout a 0xED transfer.
    a0 = acc_cnt;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clock);
    tx_if.tx_data = 8'hED;
    tx_if.tx_valid = 1'b1;
    n = 0;
    while (tx_if.tx_ready !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    tx_if.tx_data = 8'hAA;
    dev_receive(11, 1'b0, bits, ok);
    check("hold_first_bits", bits[7:0], 8'hED);
    n = 0;
    while (acc_cnt < a0 + 2 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("hold_accept_wait_expired", (n >= 2000), 0);
    @(negedge clock);
    tx_if.tx_valid = 1'b0;
    check("hold_accepts_before_done", acc_at_done - a0, 1);
    check("hold_first_done", done_cnt - d0, 1);
    dev_receive(11, 1'b0, bits, ok);
    check("hold_second_bits", bits[7:0], 8'hAA);
    check("hold_second_parity", bits[8], 1);
    wait_outcome(d0 + 1, e0);
    check("hold_total_done", done_cnt - d0, 2);
    check("hold_total_accepts", acc_cnt - a0, 2);

    check("done_err_same_cycle", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, system clock frequency.
REQ-002 SHALL have parameter INHIBIT_US, default 100, length of host clock-inhibit phase in microseconds.
REQ-003 SHALL have parameter TIMEOUT_US, default 15000, maximum time from request-to-send until ack.
REQ-004 SHALL have port clock  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tx_data  in  8  command byte to send to the device.
REQ-007 SHALL have port tx_valid  in  1  command request.
REQ-008 SHALL have port tx_ready  out  1  block idle; a byte is accepted when tx_valid && tx_ready.
REQ-009 SHALL have port ps2_clk_in  in  1  raw PS2 clock line, asynchronous.
REQ-010 SHALL have port ps2_data_in  in  1  raw PS2 data line, asynchronous.
REQ-011 SHALL have port ps2_clk_oe  out  1  1 = drive PS2 clock low; 0 = release (open drain).
REQ-012 SHALL have port ps2_data_oe  out  1  1 = drive PS2 data low; 0 = release.
REQ-013 SHALL have port tx_done  out  1  one-cycle pulse on successful, acknowledged transfer.
REQ-014 SHALL have port tx_err  out  1  one-cycle pulse on timeout or NACK.

Function
REQ-015 SHALL pass both PS2 inputs through 2-flop synchronizers; a device falling edge SHALL be detected as synced-previous 1, synced-current 0.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, DONE, ERR.
REQ-017 IDLE: tx_ready=1 and both oe=0; on accept, latch tx_data, compute odd parity (~^tx_data), and enter INHIBIT next cycle.
REQ-018 INHIBIT: ps2_clk_oe=1 for exactly CLK_FREQ_HZ/1000000*INHIBIT_US cycles, then RTS.
REQ-019 RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0; start timeout counter; enter SHIFT.
REQ-020 SHIFT: on each detected falling edge, present the next bit on the following cycle in order data[0]..data[7], parity, stop; bit b presented as ps2_data_oe=~b; stop bit releases data.
REQ-021 After the stop-bit falling edge, SHALL enter ACK; on the next falling edge, synced data 0 = ACK, 1 = NACK.
REQ-022 After ACK, WAIT_IDLE until both synced lines are 1, then DONE: tx_done=1 for one cycle, then IDLE.
REQ-023 Timeout counter expiry (CLK_FREQ_HZ/1000000*TIMEOUT_US cycles after RTS) in any of SHIFT/ACK/WAIT_IDLE SHALL go to ERR: release both lines the same cycle, tx_err=1 for one cycle, then IDLE.
REQ-024 tx_valid while tx_ready=0 SHALL be ignored; no queuing.
REQ-025 tx_ready SHALL be 0 in DONE/ERR and return to 1 the following cycle.
REQ-026 tx_done and tx_err SHALL never be asserted in the same cycle.

Reset
REQ-027 resetn low SHALL immediately force state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, tx_ready=1, counters and synchronizers to 1/idle values, including mid-transfer.

Configuration
REQ-028 With PS2_TX_ACK_CHECK_EN defined, NACK SHALL produce tx_err; without it, the ack bit is still awaited but ignored and the transfer always ends in tx_done (timeouts still give tx_err).

Structure
REQ-029 State enum, PS2 bit count (11), and microsecond-to-cycle conversion SHALL live in shared package ps2_pkg.
REQ-030 Synchronizer and falling-edge detector SHALL be sub-module ps2_sync_edge, instanced once per line.

Verification
REQ-031 Send 0xED, device model clocks at 12.5 kHz and ACKs -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done once; ps2_clk_oe high 5000 cycles.
REQ-032 Send 0xF4 -> parity bit 0; tx_done; tx_ready back high the cycle after tx_done.
REQ-033 Send 0xFF, device never clocks -> tx_err exactly 750000 cycles after RTS; both oe=0.
REQ-034 Send 0x00, device NACKs -> tx_err with PS2_TX_ACK_CHECK_EN, tx_done without it.
REQ-035 Assert resetn low after the 4th data bit -> both oe=0 immediately; new 0x01 transfer then completes with parity 0.
REQ-036 Hold tx_valid with 0xAA during a 0xED transfer -> only 0xED transmitted; 0xAA accepted only after tx_ready rises.
